// File: rtl/calc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : calc_seq
//  Description : Keypad calculator sequencer. Collects two signed decimal
//                operands and an operator from a key stream, hands them to
//                an external arithmetic unit and holds the returned result.
//                Guards against divide-by-zero and a non-responding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_seq #(
  parameter int MAX_DIGITS = 3,
  parameter int WAIT_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [10:0] op_a,
  output logic [10:0] op_b,
  output logic [1:0]  op_sel,
  output logic        op_start,
  input  logic        op_done,
  input  logic [10:0] op_result,
  output logic [10:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        err
);

  localparam int c_cnt_w  = $clog2(MAX_DIGITS + 1);
  localparam int c_wait_w = $clog2(WAIT_MAX + 1);

  localparam logic [c_cnt_w-1:0]  c_max_digits = c_cnt_w'(MAX_DIGITS);
  localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_wait_w-1:0] c_wait_last  = c_wait_w'(WAIT_MAX - 1);
  localparam logic [c_wait_w-1:0] c_wait_one   = c_wait_w'(1);

  localparam logic [3:0] c_key_plus  = 4'd10;
  localparam logic [3:0] c_key_minus = 4'd11;
  localparam logic [3:0] c_key_div   = 4'd13;
  localparam logic [3:0] c_key_enter = 4'd14;
  localparam logic [3:0] c_key_clear = 4'd15;

  localparam logic [1:0] c_sel_div = 2'd3;

  typedef enum logic [2:0] {
    S_SIGN1 = 3'd0,
    S_OPA   = 3'd1,
    S_OPER  = 3'd2,
    S_SIGN2 = 3'd3,
    S_OPB   = 3'd4,
    S_EXEC  = 3'd5,
    S_WAIT  = 3'd6,
    S_SHOW  = 3'd7
  } state_t;

  state_t              r_state,        w_state_nxt;
  logic                r_neg_a,        w_neg_a_nxt;
  logic                r_neg_b,        w_neg_b_nxt;
  logic [10:0]         r_acc_a,        w_acc_a_nxt;
  logic [10:0]         r_acc_b,        w_acc_b_nxt;
  logic [c_cnt_w-1:0]  r_cnt_a,        w_cnt_a_nxt;
  logic [c_cnt_w-1:0]  r_cnt_b,        w_cnt_b_nxt;
  logic [1:0]          r_oper,         w_oper_nxt;
  logic [10:0]         r_op_a,         w_op_a_nxt;
  logic [10:0]         r_op_b,         w_op_b_nxt;
  logic [1:0]          r_op_sel,       w_op_sel_nxt;
  logic [10:0]         r_result,       w_result_nxt;
  logic                r_result_valid, w_result_valid_nxt;
  logic                r_err,          w_err_nxt;
  logic [c_wait_w-1:0] r_wait_cnt,     w_wait_cnt_nxt;

  logic        w_is_digit;
  logic        w_is_sign;
  logic        w_is_oper;
  logic [10:0] w_digit;
  logic        w_div_zero;
  logic        w_begin_a;
  logic        w_begin_b;
  logic        w_load_ops;

  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_sign  = (key_code == c_key_plus) || (key_code == c_key_minus);
  assign w_is_oper  = (key_code >= c_key_plus) && (key_code <= c_key_div);
  assign w_digit    = {7'd0, key_code};
  // Operand B is only committed once EXEC is entered, so the check uses it directly.
  assign w_div_zero = (r_oper == c_sel_div) && (r_acc_b == 11'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_SIGN1;
    else      r_state <= w_state_nxt;
  end

  // Next-state and datapath-update logic; clear key overrides everything.
  always_comb begin
    w_state_nxt        = r_state;
    w_neg_a_nxt        = r_neg_a;
    w_neg_b_nxt        = r_neg_b;
    w_acc_a_nxt        = r_acc_a;
    w_acc_b_nxt        = r_acc_b;
    w_cnt_a_nxt        = r_cnt_a;
    w_cnt_b_nxt        = r_cnt_b;
    w_oper_nxt         = r_oper;
    w_op_a_nxt         = r_op_a;
    w_op_b_nxt         = r_op_b;
    w_op_sel_nxt       = r_op_sel;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    w_err_nxt          = r_err;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_begin_a          = 1'b0;
    w_begin_b          = 1'b0;
    w_load_ops         = 1'b0;

    case (r_state)
      S_SIGN1, S_SHOW: begin
        if (key_valid && (w_is_digit || w_is_sign)) w_begin_a = 1'b1;
      end
      S_OPA: begin
        if (key_valid) begin
          if (w_is_digit) begin
            if (r_cnt_a < c_max_digits) begin
              w_acc_a_nxt = r_acc_a * 11'd10 + w_digit;
              w_cnt_a_nxt = r_cnt_a + c_cnt_one;
            end
          end else if (key_code == c_key_enter) begin
            w_state_nxt = S_OPER;
          end else if (w_is_oper) begin
            w_oper_nxt  = 2'(key_code - c_key_plus);
            w_state_nxt = S_SIGN2;
          end
        end
      end
      S_OPER: begin
        if (key_valid && w_is_oper) begin
          w_oper_nxt  = 2'(key_code - c_key_plus);
          w_state_nxt = S_SIGN2;
        end
      end
      S_SIGN2: begin
        if (key_valid) begin
          if (w_is_digit || w_is_sign) begin
            w_begin_b = 1'b1;
          end else if (key_code == c_key_enter) begin
            w_acc_b_nxt = 11'd0;
            w_neg_b_nxt = 1'b0;
            w_load_ops  = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_OPB: begin
        if (key_valid) begin
          if (w_is_digit) begin
            if (r_cnt_b < c_max_digits) begin
              w_acc_b_nxt = r_acc_b * 11'd10 + w_digit;
              w_cnt_b_nxt = r_cnt_b + c_cnt_one;
            end
          end else if (key_code == c_key_enter) begin
            w_load_ops  = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (w_div_zero) begin
          w_err_nxt          = 1'b1;
          w_result_valid_nxt = 1'b0;
          w_state_nxt        = S_SHOW;
        end else begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (op_done) begin
          w_result_nxt       = op_result;
          w_result_valid_nxt = 1'b1;
          w_state_nxt        = S_SHOW;
        end else if (r_wait_cnt == c_wait_last) begin
          w_err_nxt          = 1'b1;
          w_result_valid_nxt = 1'b0;
          w_state_nxt        = S_SHOW;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_wait_one;
        end
      end
      default: w_state_nxt = S_SIGN1;
    endcase

    // A fresh entry wipes everything left over from the previous calculation.
    if (w_begin_a) begin
      w_neg_a_nxt        = (key_code == c_key_minus);
      w_acc_a_nxt        = w_is_digit ? w_digit : 11'd0;
      w_cnt_a_nxt        = w_is_digit ? c_cnt_one : '0;
      w_neg_b_nxt        = 1'b0;
      w_acc_b_nxt        = 11'd0;
      w_cnt_b_nxt        = '0;
      w_oper_nxt         = 2'd0;
      w_err_nxt          = 1'b0;
      w_result_valid_nxt = 1'b0;
      w_state_nxt        = S_OPA;
    end

    if (w_begin_b) begin
      w_neg_b_nxt = (key_code == c_key_minus);
      w_acc_b_nxt = w_is_digit ? w_digit : 11'd0;
      w_cnt_b_nxt = w_is_digit ? c_cnt_one : '0;
      w_state_nxt = S_OPB;
    end

    // Operands are frozen on the way into EXEC and held through WAIT.
    if (w_load_ops) begin
      w_op_a_nxt   = r_neg_a ? (~r_acc_a + 11'd1) : r_acc_a;
      w_op_b_nxt   = w_neg_b_nxt ? (~w_acc_b_nxt + 11'd1) : w_acc_b_nxt;
      w_op_sel_nxt = r_oper;
    end

    if (key_valid && (key_code == c_key_clear)) begin
      w_state_nxt        = S_SIGN1;
      w_neg_a_nxt        = 1'b0;
      w_neg_b_nxt        = 1'b0;
      w_acc_a_nxt        = 11'd0;
      w_acc_b_nxt        = 11'd0;
      w_cnt_a_nxt        = '0;
      w_cnt_b_nxt        = '0;
      w_oper_nxt         = 2'd0;
      w_op_a_nxt         = 11'd0;
      w_op_b_nxt         = 11'd0;
      w_op_sel_nxt       = 2'd0;
      w_result_nxt       = 11'd0;
      w_result_valid_nxt = 1'b0;
      w_err_nxt          = 1'b0;
      w_wait_cnt_nxt     = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_a        <= 1'b0;
      r_neg_b        <= 1'b0;
      r_acc_a        <= 11'd0;
      r_acc_b        <= 11'd0;
      r_cnt_a        <= '0;
      r_cnt_b        <= '0;
      r_oper         <= 2'd0;
      r_op_a         <= 11'd0;
      r_op_b         <= 11'd0;
      r_op_sel       <= 2'd0;
      r_result       <= 11'd0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_wait_cnt     <= '0;
    end else begin
      r_neg_a        <= w_neg_a_nxt;
      r_neg_b        <= w_neg_b_nxt;
      r_acc_a        <= w_acc_a_nxt;
      r_acc_b        <= w_acc_b_nxt;
      r_cnt_a        <= w_cnt_a_nxt;
      r_cnt_b        <= w_cnt_b_nxt;
      r_oper         <= w_oper_nxt;
      r_op_a         <= w_op_a_nxt;
      r_op_b         <= w_op_b_nxt;
      r_op_sel       <= w_op_sel_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_err          <= w_err_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
    end
  end

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign op_sel       = r_op_sel;
  assign op_start     = (r_state == S_EXEC) && !w_div_zero;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = (r_state == S_EXEC) || (r_state == S_WAIT);
  assign err          = r_err;

endmodule
`default_nettype wire
